pmem_line_arbiter: RTL and testbench

- Sits between the instruction cache, the data cache and the single physical-memory port of mp3.
- Arbitrates 256-bit cacheline read/write requests from both caches.
- Converts each line transfer into a 4-beat, 64-bit burst on pmem_* and reassembles read bursts into a full line.
- Exactly one transaction is in flight at a time.

---
 rtl/pmem_line_arbiter.sv | 159 +++++++++++++++
 tb/tb_pmem_line_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmem_line_arbiter.sv
// pmem_line_arbiter: shares the single physical-memory port between the I-cache and the
// D-cache. Each 256-bit line transfer becomes a 4-beat, 64-bit burst on pmem_*.
// Read bursts are reassembled into a line buffer that feeds both caches.
// Only one transaction is in flight at a time.
//
// Optional feature (compile-time macro PMEM_ARB_RR_EN):
//   When PMEM_ARB_RR_EN is defined, a 1-bit last_grant register makes I and D alternate
//   whenever both caches request at the same time.
//   When it is undefined, the D-cache always has priority over the I-cache.
module pmem_line_arbiter #(
   parameter int unsigned BEATS  = 4,
   parameter int unsigned BEAT_W = 64,
   parameter int unsigned LINE_W = 256   // must equal BEATS*BEAT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_read,
   input  logic [31:0]       i_address,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_resp,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [31:0]       d_address,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_resp,
   output logic              pmem_read,
   output logic              pmem_write,
   output logic [31:0]       pmem_address,
   output logic [BEAT_W-1:0] pmem_wdata,
   input  logic [BEAT_W-1:0] pmem_rdata,
   input  logic              pmem_resp
);

   localparam int unsigned   KW        = $clog2(BEATS);
   localparam logic [KW-1:0] LAST_BEAT = KW'(BEATS - 1);
   // Byte-offset bits inside a line; cleared so every burst is line aligned.
   localparam logic [31:0]   OFF_MASK  = 32'(LINE_W / 8 - 1);

   typedef enum logic [2:0] {StIdle, StIRd, StDRd, StDWr, StDone} state_e;
   typedef enum logic [1:0] {GntNone, GntI, GntD} grant_e;

   state_e            state_q;
   grant_e            grant_q;
   logic [KW-1:0]     k_q;
   logic [LINE_W-1:0] buf_q;
   logic [LINE_W-1:0] wline_q;
   logic              pick_i;
   logic              pick_d;

`ifdef PMEM_ARB_RR_EN
   logic last_grant_q;  // 0 = D served last, 1 = I served last

   // Arbitration: on a conflict the side not served last wins.
   always_comb begin
      pick_d = 1'b0;
      pick_i = 1'b0;
      if ((d_read || d_write) && i_read) begin
         pick_i = ~last_grant_q;
         pick_d = last_grant_q;
      end else begin
         pick_d = d_read || d_write;
         pick_i = i_read;
      end
   end

   // Remember which side received the most recent grant.
   always_ff @(posedge clk) begin
      if (!rst) begin
         last_grant_q <= 1'b0;
      end else if (state_q == StIdle && (pick_d || pick_i)) begin
         last_grant_q <= pick_i;
      end
   end
`else
   // Arbitration: fixed D-over-I priority.
   always_comb begin
      pick_d = d_read || d_write;
      pick_i = i_read && !(d_read || d_write);
   end
`endif

   // Main FSM with registered strobes, address and responses.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= StIdle;
         grant_q      <= GntNone;
         k_q          <= '0;
         buf_q        <= '0;
         wline_q      <= '0;
         pmem_address <= '0;
         pmem_read    <= 1'b0;
         pmem_write   <= 1'b0;
         i_resp       <= 1'b0;
         d_resp       <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (pick_d) begin
                  grant_q      <= GntD;
                  pmem_address <= d_address & ~OFF_MASK;
                  // d_write wins if a D-cache ever raises both strobes.
                  if (d_write) begin
                     state_q    <= StDWr;
                     pmem_write <= 1'b1;
                     wline_q    <= d_wdata;
                  end else begin
                     state_q   <= StDRd;
                     pmem_read <= 1'b1;
                  end
               end else if (pick_i) begin
                  grant_q      <= GntI;
                  pmem_address <= i_address & ~OFF_MASK;
                  state_q      <= StIRd;
                  pmem_read    <= 1'b1;
               end
            end
            StIRd, StDRd, StDWr: begin
               if (pmem_resp) begin
                  if (state_q != StDWr) begin
                     buf_q[BEAT_W*k_q +: BEAT_W] <= pmem_rdata;
                  end
                  k_q <= k_q + 1'b1;  // wraps to 0 after the last beat
                  if (k_q == LAST_BEAT) begin
                     state_q    <= StDone;
                     pmem_read  <= 1'b0;
                     pmem_write <= 1'b0;
                     i_resp     <= (grant_q == GntI);
                     d_resp     <= (grant_q == GntD);
                  end
               end
            end
            StDone: begin
               // Always pass through IDLE so a cache that drops its request on resp is
               // never granted a second time.
               i_resp  <= 1'b0;
               d_resp  <= 1'b0;
               grant_q <= GntNone;
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   // Write beat selected by the beat counter; quiet outside writebacks.
   always_comb begin
      pmem_wdata = '0;
      if (state_q == StDWr) begin
         pmem_wdata = wline_q[BEAT_W*k_q +: BEAT_W];
      end
   end

   assign i_rdata = buf_q;
   assign d_rdata = buf_q;

endmodule

// File: tb/tb_pmem_line_arbiter.sv
// Bench for pmem_line_arbiter. The driver pushes expected responses and bursts into
// queues. A memory responder and a response monitor pop and compare them independently.
// The arbitration model follows PMEM_ARB_RR_EN in the same way as the design.
module tb_pmem_line_arbiter;

   logic         clk = 1'b0;
   logic         rst;
   logic         i_read, d_read, d_write;
   logic [31:0]  i_address, d_address, pmem_address;
   logic [255:0] i_rdata, d_rdata, d_wdata;
   logic         i_resp, d_resp, pmem_read, pmem_write, pmem_resp;
   logic [63:0]  pmem_wdata, pmem_rdata;

   pmem_line_arbiter #(.BEATS(4), .BEAT_W(64), .LINE_W(256)) dut (
      .clk         (clk),
      .rst         (rst),
      .i_read      (i_read),
      .i_address   (i_address),
      .i_rdata     (i_rdata),
      .i_resp      (i_resp),
      .d_read      (d_read),
      .d_write     (d_write),
      .d_address   (d_address),
      .d_wdata     (d_wdata),
      .d_rdata     (d_rdata),
      .d_resp      (d_resp),
      .pmem_read   (pmem_read),
      .pmem_write  (pmem_write),
      .pmem_address(pmem_address),
      .pmem_wdata  (pmem_wdata),
      .pmem_rdata  (pmem_rdata),
      .pmem_resp   (pmem_resp)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit           is_i;
      bit           wr;
      logic [31:0]  addr;
      logic [255:0] line;
   } txn_t;

   txn_t         exp_q[$];   // expected cache responses, in completion order
   txn_t         exp_b[$];   // expected pmem bursts, in issue order
   logic [255:0] model_mem[logic [31:0]];
   logic [255:0] pm_mem[logic [31:0]];
   bit           m_last_i = 1'b0;
   bit           auto_mem = 1'b0;
   int           wait_fixed = -1;
   int           last_hi = 0;
   int           last_gap = 0;
   int unsigned  done_cyc = 0;
   int           checks = 0;
   int           failures = 0;

   task automatic chk_eq(input string name, input logic [255:0] act, input logic [255:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Memory contents of a line that has never been written.
   function automatic logic [255:0] default_line(input logic [31:0] a);
      logic [255:0] l;
      for (int b = 0; b < 4; b++) begin
         l[64*b +: 64] = {a ^ 32'h9E37_79B9, a + 32'(b + 1) * 32'h0101_0101};
      end
      return l;
   endfunction

   task automatic expect_txn(input bit is_i, input bit wr, input logic [31:0] addr,
                             input logic [255:0] wd);
      logic [31:0]  a;
      logic [255:0] l;
      a = {addr[31:5], 5'b0};
      if (wr) begin
         l = wd;
         model_mem[a] = wd;
      end else begin
         l = model_mem.exists(a) ? model_mem[a] : default_line(a);
      end
      exp_q.push_back('{is_i: is_i, wr: wr, addr: a, line: l});
      exp_b.push_back('{is_i: is_i, wr: wr, addr: a, line: l});
      m_last_i = is_i;
   endtask

   task automatic check_zero(input string tag);
      chk_eq({tag, "_ctrl"}, {i_resp, d_resp, pmem_read, pmem_write}, 4'b0);
      chk_eq({tag, "_addr"}, pmem_address, 0);
      chk_eq({tag, "_wdata"}, pmem_wdata, 0);
      chk_eq({tag, "_irdata"}, i_rdata, 0);
      chk_eq({tag, "_drdata"}, d_rdata, 0);
   endtask

   // One arbitration round: raise the requests, drop each one on its resp.
   task automatic do_round(input bit ri, input bit rq_d, input bit dw, input logic [31:0] ia,
                           input logic [31:0] da, input logic [255:0] wd);
      bit i_first;
      i_first = ri && !rq_d;
      if (ri && rq_d) begin
`ifdef PMEM_ARB_RR_EN
         i_first = !m_last_i;
`else
         i_first = 1'b0;
`endif
      end
      if (i_first) expect_txn(1'b1, 1'b0, ia, '0);
      if (rq_d) expect_txn(1'b0, dw, da, wd);
      if (ri && !i_first) expect_txn(1'b1, 1'b0, ia, '0);
      @(negedge clk);
      i_address = ia;
      d_address = da;
      d_wdata   = wd;
      i_read    = ri;
      d_read    = rq_d && !dw;
      d_write   = rq_d && dw;
      for (int c = 0; c < 200 && (i_read || d_read || d_write); c++) begin
         @(negedge clk);
         if (i_resp) i_read = 1'b0;
         if (d_resp) begin
            d_read  = 1'b0;
            d_write = 1'b0;
         end
      end
      chk_eq("round_done", {i_read, d_read, d_write}, 3'b000);
   endtask

   task automatic wait_dresp();
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (d_resp) break;
      end
      chk_eq("d_resp_seen", d_resp, 1'b1);
   endtask

   // Memory responder: serves bursts with wait states and checks the pmem protocol.
   initial begin : responder
      logic [31:0]  a;
      bit           wr;
      logic [255:0] rl, wl;
      int           hi, n;
      txn_t         e;
      pmem_resp  = 1'b0;
      pmem_rdata = '0;
      forever begin
         @(negedge clk);
         if (auto_mem && rst && (pmem_read || pmem_write)) begin
            a        = pmem_address;
            wr       = pmem_write;
            last_gap = int'(cyc - done_cyc);
            hi       = 0;
            wl       = '0;
            e        = '{is_i: 1'b0, wr: wr, addr: a, line: '0};
            chk_eq("burst_expected", exp_b.size() != 0, 1'b1);
            if (exp_b.size() != 0) begin
               e = exp_b.pop_front();
               chk_eq("burst_kind", wr, e.wr);
               chk_eq("burst_addr", a, e.addr);
            end
            rl = pm_mem.exists(a) ? pm_mem[a] : default_line(a);
            for (int b = 0; b < 4; b++) begin
               n = (wait_fixed >= 0) ? wait_fixed : int'($urandom_range(0, 2));
               for (int w = 0; w <= n; w++) begin
                  chk_eq("burst_strobe", {pmem_read, pmem_write, pmem_address}, {~wr, wr, a});
                  hi++;
                  if (w == n) begin
                     pmem_resp  = 1'b1;
                     pmem_rdata = rl[64*b +: 64];
                     if (wr) wl[64*b +: 64] = pmem_wdata;
                  end else begin
                     pmem_resp  = 1'b0;
                     pmem_rdata = {$urandom, $urandom};
                  end
                  @(negedge clk);
               end
            end
            pmem_resp = 1'b0;
            chk_eq("burst_end", {pmem_read, pmem_write}, 2'b00);
            done_cyc = cyc;
            last_hi  = hi;
            if (wr) begin
               chk_eq("burst_wdata", wl, e.line);
               pm_mem[a] = wl;
            end
         end
      end
   end

   // Response monitor: every resp pulse must match the next expected transaction.
   initial begin : monitor
      txn_t e;
      forever begin
         @(negedge clk);
         if (rst && (i_resp || d_resp)) begin
            chk_eq("resp_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk_eq("resp_who", {i_resp, d_resp}, {e.is_i, ~e.is_i});
               if (!e.wr) chk_eq("rdata", e.is_i ? i_rdata : d_rdata, e.line);
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin : main
      logic [63:0]  beats[4];
      logic [255:0] lat_line, wd, save;
      logic [31:0]  ia, da;
      int           kind;
      rst = 1'b0; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
      i_address = '0; d_address = '0; d_wdata = '0;
      repeat (3) @(negedge clk);
      check_zero("reset");
      rst = 1'b1;

      // Reset in the middle of an I-cache burst.
      @(negedge clk);
      i_address = 32'h64;
      i_read    = 1'b1;
      @(negedge clk);
      pmem_resp  = 1'b1;
      pmem_rdata = 64'hDEAD_BEEF_0000_0001;
      @(negedge clk);
      pmem_rdata = 64'hDEAD_BEEF_0000_0002;
      @(negedge clk);
      pmem_resp = 1'b0;
      chk_eq("midrst_strobe", pmem_read, 1'b1);
      rst = 1'b0;
      @(negedge clk);
      check_zero("midrst");
      rst    = 1'b1;
      i_read = 1'b0;
      m_last_i = 1'b0;
      auto_mem = 1'b1;
      do_round(1'b1, 1'b0, 1'b0, 32'h60, '0, '0);

      // Zero-wait I-cache read with exact latency.
      auto_mem = 1'b0;
      beats[0] = {16{4'h1}};
      beats[1] = {16{4'h2}};
      beats[2] = {16{4'h3}};
      beats[3] = {16{4'h4}};
      lat_line = {beats[3], beats[2], beats[1], beats[0]};
      @(negedge clk);
      i_address = 32'h0000_0064;
      i_read    = 1'b1;
      exp_q.push_back('{is_i: 1'b1, wr: 1'b0, addr: 32'h60, line: lat_line});
      m_last_i = 1'b1;
      for (int b = 0; b < 4; b++) begin
         @(negedge clk);
         chk_eq("lat_strobe", {pmem_read, pmem_write, pmem_address}, {1'b1, 1'b0, 32'h60});
         pmem_resp  = 1'b1;
         pmem_rdata = beats[b];
      end
      @(negedge clk);
      pmem_resp = 1'b0;
      chk_eq("lat_resp", {i_resp, d_resp, pmem_read}, 3'b100);
      i_read = 1'b0;
      @(negedge clk);
      chk_eq("lat_pulse", {i_resp, d_resp}, 2'b00);

      // Stray pmem_resp while idle.
      save = i_rdata;
      for (int s = 0; s < 3; s++) begin
         @(negedge clk);
         pmem_resp  = 1'b1;
         pmem_rdata = {$urandom, $urandom};
         @(negedge clk);
         pmem_resp = 1'b0;
         chk_eq("stray_quiet", {pmem_read, pmem_write, i_resp, d_resp}, 4'b0);
         chk_eq("stray_buf", i_rdata, save);
      end

      // Writeback with two wait cycles before every beat, then read it back.
      auto_mem   = 1'b1;
      wait_fixed = 2;
      wd = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
      do_round(1'b0, 1'b1, 1'b1, '0, 32'h8000_01E0, wd);
      chk_eq("wr_strobe_len", last_hi, 12);
      wait_fixed = -1;
      do_round(1'b0, 1'b1, 1'b0, '0, 32'h8000_01E0, '0);

      // Back-to-back D reads with the request held across the response.
      @(negedge clk);
      expect_txn(1'b0, 1'b0, 32'h100, '0);
      expect_txn(1'b0, 1'b0, 32'h120, '0);
      d_address = 32'h100;
      d_read    = 1'b1;
      wait_dresp();
      d_address = 32'h120;
      wait_dresp();
      d_read = 1'b0;
      chk_eq("b2b_gap", last_gap, 2);

      // Simultaneous requests, then randomized rounds.
      do_round(1'b1, 1'b1, 1'b0, 32'h200, 32'h240, '0);
      do_round(1'b1, 1'b1, 1'b0, 32'h260, 32'h280, '0);
      do_round(1'b1, 1'b1, 1'b1, 32'h2A0, 32'h2A0, ~wd);
      for (int r = 0; r < 40; r++) begin
         kind = int'($urandom_range(0, 4));
         ia = 32'h1000 + 32'($urandom_range(0, 7)) * 32 + 32'($urandom_range(0, 31));
         da = 32'h1000 + 32'($urandom_range(0, 7)) * 32 + 32'($urandom_range(0, 31));
         wd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         do_round(kind == 0 || kind >= 3, kind != 0, kind == 2 || kind == 4, ia, da, wd);
      end

      repeat (3) @(negedge clk);
      chk_eq("queues_empty", exp_q.size() + exp_b.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
